// File: rtl/embedded_system_nios2_qsys_0_mul_seq_pkg.sv
// rtl/embedded_system_nios2_qsys_0_mul_seq_pkg.sv - shared op codes, FSM states and partial-product constants
package embedded_system_nios2_qsys_0_mul_seq_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MUL    = 2'b00;
  localparam op_t OP_MULXUU = 2'b01;
  localparam op_t OP_MULXSU = 2'b10;
  localparam op_t OP_MULXSS = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int NPP_MUL  = 3;
  localparam int NPP_MULX = 4;

  // Partial products alo*blo, ahi*blo, alo*bhi, ahi*bhi land at bit 0, 16, 16, 32.
  function automatic logic [5:0] pp_shift(input logic [1:0] idx);
    case (idx)
      2'd0:    pp_shift = 6'd0;
      2'd3:    pp_shift = 6'd32;
      default: pp_shift = 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/embedded_system_nios2_qsys_0_mul_seq_mult16.sv
// rtl/embedded_system_nios2_qsys_0_mul_seq_mult16.sv - 16x16 unsigned multiplier with LATENCY register stages
module embedded_system_nios2_qsys_0_mul_seq_mult16 #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] pipe [LATENCY];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= 32'(a) * 32'(b);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[LATENCY-1];

endmodule

// File: rtl/embedded_system_nios2_qsys_0_mul_sequencer.sv
// rtl/embedded_system_nios2_qsys_0_mul_sequencer.sv - 32x32 multiply sequencer sharing one 16x16 multiplier
module embedded_system_nios2_qsys_0_mul_sequencer
  import embedded_system_nios2_qsys_0_mul_seq_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        busy
);

  logic [2:0]             state;
  op_t                    op_q;
  logic [31:0]            src1_q, src2_q;
  logic [1:0]             iss_cnt, acc_cnt;
  logic [63:0]            acc;
  logic [MUL_LATENCY-1:0] tag_sr;
  logic [31:0]            result_q;
  logic [31:0]            prod;
  logic [15:0]            mul_a, mul_b;
  logic [1:0]             n_last;
  logic                   issue, tag_out;
  logic [31:0]            fixed_result;

  assign issue   = (state == ST_ISSUE);
  assign tag_out = tag_sr[MUL_LATENCY-1];
  assign n_last  = (op_q == OP_MUL) ? 2'(NPP_MUL - 1) : 2'(NPP_MULX - 1);
  // Bit 0 of the issue index picks the src1 half, bit 1 the src2 half.
  assign mul_a   = iss_cnt[0] ? src1_q[31:16] : src1_q[15:0];
  assign mul_b   = iss_cnt[1] ? src2_q[31:16] : src2_q[15:0];

  embedded_system_nios2_qsys_0_mul_seq_mult16 #(.LATENCY(MUL_LATENCY)) u_mult (
    .clk (clk),
    .clr (reset),
    .a   (mul_a),
    .b   (mul_b),
    .p   (prod)
  );

  // Signed high word = unsigned high word minus the other operand for each negative signed input.
  always_comb begin
    fixed_result = acc[63:32];
    if ((op_q == OP_MULXSS || op_q == OP_MULXSU) && src1_q[31]) fixed_result = fixed_result - src2_q;
    if (op_q == OP_MULXSS && src2_q[31]) fixed_result = fixed_result - src1_q;
    if (op_q == OP_MUL) fixed_result = acc[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MUL;
      src1_q   <= '0;
      src2_q   <= '0;
      iss_cnt  <= '0;
      acc_cnt  <= '0;
      acc      <= '0;
      tag_sr   <= '0;
      result_q <= '0;
    end else begin
      tag_sr[0] <= issue;
      for (int i = 1; i < MUL_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
      if (tag_out) begin
        acc     <= acc + ({32'd0, prod} << pp_shift(acc_cnt));
        acc_cnt <= acc_cnt + 2'd1;
      end
      case (state)
        ST_IDLE: if (req_valid) begin
          op_q    <= req_op;
          src1_q  <= req_src1;
          src2_q  <= req_src2;
          acc     <= '0;
          acc_cnt <= '0;
          iss_cnt <= '0;
          state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          iss_cnt <= iss_cnt + 2'd1;
          if (iss_cnt == n_last) state <= ST_DRAIN;
        end
        ST_DRAIN: if (tag_out && acc_cnt == n_last) state <= ST_FIX;
        ST_FIX: begin
          result_q <= fixed_result;
          state    <= ST_RESP;
        end
        ST_RESP: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == ST_IDLE) && !reset;
  assign resp_valid  = (state == ST_RESP);
  assign resp_result = result_q;
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_embedded_system_nios2_qsys_0_mul_sequencer.sv
// tb/tb_embedded_system_nios2_qsys_0_mul_sequencer.sv - directed-vector bench for the multiply sequencer at latency 1 and 3
module tb_embedded_system_nios2_qsys_0_mul_sequencer;
  import embedded_system_nios2_qsys_0_mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        req_valid1, req_valid3, resp_ready1, resp_ready3;
  logic        req_ready1, req_ready3, resp_valid1, resp_valid3, busy1, busy3;
  logic [31:0] resp_result1, resp_result3;
  int          n_vec = 0;
  int          n_miss = 0;
  int          sel = 1;
  logic        o_rv, o_rr, o_busy;
  logic [31:0] o_res;

  always #5 clk = ~clk;

  embedded_system_nios2_qsys_0_mul_sequencer #(.MUL_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_result(resp_result1), .busy(busy1)
  );

  embedded_system_nios2_qsys_0_mul_sequencer #(.MUL_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_result(resp_result3), .busy(busy3)
  );

  assign o_rv   = (sel == 3) ? resp_valid3  : resp_valid1;
  assign o_rr   = (sel == 3) ? req_ready3   : req_ready1;
  assign o_busy = (sel == 3) ? busy3        : busy1;
  assign o_res  = (sel == 3) ? resp_result3 : resp_result1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s (L=%0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask

  task automatic drive_valid(input logic v);
    if (sel == 3) req_valid3 = v; else req_valid1 = v;
  endtask

  task automatic drive_ready(input logic v);
    if (sel == 3) resp_ready3 = v; else resp_ready1 = v;
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic rdy);
    @(negedge clk);
    chk("req_ready_idle", 32'(o_rr), 32'd1);
    req_op = op; req_src1 = a; req_src2 = b;
    drive_valid(1'b1);
    drive_ready(rdy);
    @(posedge clk);
    @(negedge clk);
    drive_valid(1'b0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_cyc, input logic hold);
    int cyc;
    logic [31:0] held;
    accept(op, a, b, !hold);
    cyc = 1;
    while (!o_rv && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(exp_cyc));
    chk("result", o_res, exp);
    if (hold) begin
      held = o_res;
      repeat (5) begin
        @(negedge clk);
        chk("hold_valid", 32'(o_rv), 32'd1);
        chk("hold_result", o_res, held);
        chk("hold_req_ready", 32'(o_rr), 32'd0);
        chk("hold_busy", 32'(o_busy), 32'd1);
      end
      drive_ready(1'b1);
    end
    @(negedge clk);
    chk("resp_drop", 32'(o_rv), 32'd0);
    chk("back_idle", 32'(o_rr), 32'd1);
    chk("busy_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid1 = 1'b0; req_valid3 = 1'b0; resp_ready1 = 1'b0; resp_ready3 = 1'b0;
    req_op = OP_MUL; req_src1 = '0; req_src2 = '0;
    @(negedge clk);
    for (int l = 1; l <= 3; l += 2) begin
      sel = l;
      #1;
      chk("rst_resp_valid", 32'(o_rv), 32'd0);
      chk("rst_result", o_res, 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    sel = 1;
    chk("rst_req_ready", 32'(o_rr), 32'd1);

    sel = 1;
    run_op(OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 6, 1'b0);
    run_op(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, 1'b0);
    run_op(OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7, 1'b0);
    run_op(OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 1'b0);
    run_op(OP_MULXSS, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 7, 1'b0);
    run_op(OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7, 1'b0);
    run_op(OP_MUL,    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 6, 1'b0);
    run_op(OP_MULXUU, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 7, 1'b1);

    sel = 3;
    run_op(OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 8, 1'b0);
    run_op(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 1'b0);
    run_op(OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 9, 1'b0);
    run_op(OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 1'b0);

    // MULXSS at latency 3 is in DRAIN during cycles 5..7; reset hits cycle 6.
    accept(OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 32'(o_rv), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_result", o_res, 32'd0);
    chk("mid_rst_req_ready", 32'(o_rr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(o_rr), 32'd1);
    run_op(OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 8, 1'b0);

    sel = 1;
    run_op(OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/embedded_system_nios2_qsys_0_mul_sequencer.md
EMBEDDED_SYSTEM_NIOS2_QSYS_0_MUL_SEQUENCER -- requirements
Module: embedded_system_nios2_qsys_0_mul_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have parameter MUL_LATENCY, default 1, giving the 16x16 multiplier pipeline depth in cycles (legal range 1..3).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  operation request.
REQ-006 req_ready  output  1  sequencer idle; accepts a request.
REQ-007 req_op  input  2  operation code: 00 MUL (low word), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS (high words).
REQ-008 req_src1, req_src2  input  32 each  operands.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer takes the result.
REQ-011 resp_result  output  32  selected product word.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL accept a request on a rising edge where req_valid and req_ready are both high, and latch the op and both operands.
REQ-014 req_ready SHALL be high only in IDLE.
REQ-015 The state machine SHALL have the states IDLE, ISSUE, DRAIN, FIX and RESP. The transitions SHALL be:
  - IDLE -> ISSUE on acceptance.
  - ISSUE -> DRAIN after the last issue.
  - DRAIN -> FIX when every issued product has been accumulated.
  - FIX -> RESP unconditionally.
  - RESP -> IDLE when resp_ready is high.
REQ-016 In ISSUE, the block SHALL issue one partial product per cycle, in order: alo*blo, ahi*blo, alo*bhi, ahi*bhi.
  - MUL issues only the first three (N=3).
  - The MULX ops issue all four (N=4).
REQ-017 A valid tag SHALL travel with each issue through a MUL_LATENCY-deep shift register. Each returning product SHALL be added into a 64-bit accumulator at shift 0, 16, 16 or 32 respectively.
REQ-018 In FIX, the high word SHALL be corrected modulo 2^32:
  - MULXSS: subtract src2 if src1[31] is set; subtract src1 if src2[31] is set.
  - MULXSU: subtract src2 if src1[31] is set.
  - MUL and MULXUU: no correction.
REQ-019 resp_result SHALL be the accumulator low word for MUL and the corrected high word otherwise.
REQ-020 Latency: taking the acceptance edge as the end of cycle 0, resp_valid SHALL rise in cycle N+MUL_LATENCY+2.
  - MUL, L=1: cycle 6.
  - MULX, L=1: cycle 7.
REQ-021 resp_valid and resp_result SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-022 resp_valid SHALL drop in the cycle after the resp handshake edge, and the state SHALL return to IDLE.
REQ-023 If resp_ready is already high when RESP is entered, the response SHALL complete in exactly one cycle.
REQ-024 A new request SHALL never be accepted in the same cycle as a resp handshake; back-to-back operation costs one IDLE cycle.
REQ-025 The accumulator SHALL be cleared on acceptance. No partial product of an earlier operation SHALL contribute to a later one.
REQ-026 Operands of zero SHALL take the full latency; there SHALL be no early-out.

Reset
REQ-027 On reset assertion, the block SHALL immediately enter IDLE and SHALL:
  - clear the accumulator, valid-tag pipeline, latched op and operands;
  - drive req_ready=1 (once deasserted), resp_valid=0, resp_result=0, busy=0.
REQ-028 Reset asserted mid-operation SHALL discard the operation. After reset deasserts, no stale product SHALL be accumulated or reported.
REQ-029 The multiplier sub-module pipeline SHALL be cleared by the same reset.

Structure
REQ-030 The op codes, the state enumeration and the partial-product count constants (3, 4) SHALL reside in package embedded_system_nios2_qsys_0_mul_seq_pkg.
REQ-031 The 16x16 unsigned pipelined multiplier SHALL be a single sub-module, embedded_system_nios2_qsys_0_mul_seq_mult16, with MUL_LATENCY register stages, async active-high clear, and a 32-bit result.
REQ-032 The sequencer SHALL contain only one multiplier instance. All four partial products SHALL share it.

Verification
REQ-033 MUL with src1=0x00010003, src2=0x00020005 -> resp_result=0x000B000F; resp_valid in cycle 6 (L=1).
REQ-034 MULXUU with 0xFFFFFFFF * 0xFFFFFFFF -> resp_result=0xFFFFFFFE; MULXSS with the same operands -> resp_result=0x00000000; MULXSU with the same operands -> resp_result=0xFFFFFFFF.
REQ-035 MULXSS with 0x80000000 * 0x00000002 -> resp_result=0xFFFFFFFF; MULXSS with 0x80000000 * 0x80000000 -> resp_result=0x40000000.
REQ-036 Hold resp_ready low for 5 cycles after resp_valid rises -> resp_result stable, req_ready=0, busy=1; resp_ready high -> IDLE next cycle, req_ready=1.
REQ-037 Assert reset in the second DRAIN cycle of a MULXSS -> outputs reach reset values immediately; a following MUL 3*5 -> resp_result=0x0000000F with no contamination.
REQ-038 Repeat REQ-033 and REQ-034 with MUL_LATENCY=3 -> the same results, with resp_valid in cycles 8 and 9 respectively.
